// File: rtl/mul_share_ctrl_pkg.sv
// rtl/mul_share_ctrl_pkg.sv - shared CPU multiplier package: FSM encodings and datapath width
package mul_share_ctrl_pkg;

    localparam int MUL_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_share_ctrl_if.sv
// rtl/mul_share_ctrl_if.sv - requester/response bus of the shared multiplier controller
interface mul_share_ctrl_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
);
    import mul_share_ctrl_pkg::*;

    logic [NREQ-1:0]       req_valid;
    logic [MUL_W*NREQ-1:0] req_a;
    logic [MUL_W*NREQ-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [MUL_W-1:0]      rsp_result;
    logic [MUL_W*NREQ-1:0] grant_cnt;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, grant_cnt
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, grant_cnt
    );

endinterface

// File: rtl/mul_share_ctrl_mul.sv
// rtl/mul_share_ctrl_mul.sv - karatsuba_mul_16: signed 16x16 multiply, low 16 product bits
module karatsuba_mul_16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_p
);
    logic [15:0] w_z0;
    logic [15:0] w_z2;
    logic [8:0]  w_sa;
    logic [8:0]  w_sb;
    logic [7:0]  w_z1;

    // Low 16 bits of a two's-complement product equal those of the unsigned
    // product, so only z0 and the low byte of the middle term matter.
    assign w_z0 = i_a[7:0] * i_b[7:0];
    assign w_z2 = i_a[15:8] * i_b[15:8];
    assign w_sa = {1'b0, i_a[15:8]} + {1'b0, i_a[7:0]};
    assign w_sb = {1'b0, i_b[15:8]} + {1'b0, i_b[7:0]};
    assign w_z1 = 8'({9'b0, w_sa} * {9'b0, w_sb} - {2'b0, w_z2} - {2'b0, w_z0});
    assign o_p  = w_z0 + {w_z1, 8'h00};

endmodule

// File: rtl/mul_share_ctrl.sv
// rtl/mul_share_ctrl.sv - round-robin sharing of one multiplier; MUL_SHARE_STATS_EN adds grant counters
module mul_share_ctrl
    import mul_share_ctrl_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mul_share_ctrl_if.slave      bus
);
    state_e           r_state;
    state_e           w_state_nxt;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_id;
    logic [MUL_W-1:0] r_a;
    logic [MUL_W-1:0] r_b;
    logic [MUL_W-1:0] r_result;
    logic [MUL_W-1:0] w_prod;
    logic [IDW-1:0]   w_sel;
    logic             w_found;
    logic             w_hs;
    int               w_best_d;
    int               w_dist;

    // Pick the valid requester closest to r_rr_ptr going upward with wrap.
    always_comb begin
        w_best_d = NREQ;
        w_dist   = 0;
        w_sel    = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = i - int'(r_rr_ptr);
            if (w_dist < 0) w_dist = w_dist + NREQ;
            if (bus.req_valid[i] && (w_dist < w_best_d)) begin
                w_best_d = w_dist;
                w_sel    = IDW'(i);
            end
        end
    end

    assign w_found = (w_best_d < NREQ);
    assign w_hs    = |(bus.req_valid & bus.req_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_state_nxt = BUSY;
            BUSY:    w_state_nxt = DONE;
            DONE:    if (bus.rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = 1'b0;
        if ((r_state == IDLE) && w_found && rst_n) bus.req_ready = NREQ'(1) << w_sel;
        if (r_state == DONE) bus.rsp_valid = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_id     <= '0;
            r_rr_ptr <= '0;
            r_result <= '0;
        end else begin
            if (w_hs) begin
                r_a      <= bus.req_a[w_sel*MUL_W +: MUL_W];
                r_b      <= bus.req_b[w_sel*MUL_W +: MUL_W];
                r_id     <= w_sel;
                r_rr_ptr <= (w_sel == IDW'(NREQ-1)) ? '0 : w_sel + 1'b1;
            end
            if (r_state == BUSY) r_result <= w_prod;
        end
    end

    karatsuba_mul_16 u_mul (
        .i_a (r_a),
        .i_b (r_b),
        .o_p (w_prod)
    );

    assign bus.rsp_id     = r_id;
    assign bus.rsp_result = r_result;

`ifdef MUL_SHARE_STATS_EN
    logic [MUL_W-1:0] r_cnt [NREQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
        end else if (w_hs && (r_cnt[w_sel] != '1)) begin
            r_cnt[w_sel] <= r_cnt[w_sel] + 1'b1;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
        assign bus.grant_cnt[g*MUL_W +: MUL_W] = r_cnt[g];
    end
`else
    assign bus.grant_cnt = '0;
`endif

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb/tb_mul_share_ctrl.sv - randomized self-checking bench for mul_share_ctrl
module tb_mul_share_ctrl;
    localparam int NREQ = 2;
    localparam int IDW  = 1;
`ifdef MUL_SHARE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_share_ctrl_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    mul_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          mdl_ptr = 0;
    int          mdl_cnt [NREQ];
    logic [15:0] op_a [NREQ];
    logic [15:0] op_b [NREQ];

    function automatic int pick(input logic [NREQ-1:0] v);
        int j;
        for (int k = 0; k < NREQ; k++) begin
            j = (mdl_ptr + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int idx);
        if (idx < 0) return '0;
        return NREQ'(1) << idx;
    endfunction

    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    function automatic logic [15:0] exp_cnt(input int idx);
        return STATS ? 16'(mdl_cnt[idx]) : 16'h0000;
    endfunction

    task automatic drive_ops(input logic [NREQ-1:0] v);
        bus.req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*16 +: 16] = op_a[i];
            bus.req_b[i*16 +: 16] = op_b[i];
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mdl_ptr = 0;
        for (int i = 0; i < NREQ; i++) mdl_cnt[i] = 0;
    endtask

    // One complete operation: grant, BUSY, DONE (optionally stalled), back to IDLE.
    task automatic run_op(input logic [NREQ-1:0] v, input int stall);
        int          g;
        logic [15:0] exp_r;
        logic [NREQ-1:0] exp_g;
        g = pick(v);
        exp_g = onehot(g);
        exp_r = ref_mul(op_a[g], op_b[g]);
        drive_ops(v);
        bus.rsp_ready = (stall == 0);
        #1;
        n_checks++; if (bus.req_ready !== exp_g) begin n_fail++; $display("FAIL grant: got %b want %b", bus.req_ready, exp_g); end
        @(posedge clk);
        mdl_ptr = (g + 1) % NREQ;
        if (mdl_cnt[g] < 65535) mdl_cnt[g]++;
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL busy_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_checks++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL busy_req_ready: got %b want 0", bus.req_ready); end
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL done_rsp_valid: got %b want 1", bus.rsp_valid); end
        n_checks++; if (bus.rsp_result !== exp_r) begin n_fail++; $display("FAIL done_result: a=%h b=%h got %h want %h", op_a[g], op_b[g], bus.rsp_result, exp_r); end
        n_checks++; if (bus.rsp_id !== IDW'(g)) begin n_fail++; $display("FAIL done_id: got %0d want %0d", bus.rsp_id, g); end
        n_checks++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL done_req_ready: got %b want 0", bus.req_ready); end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL stall_rsp_valid: got %b want 1", bus.rsp_valid); end
            n_checks++; if (bus.rsp_result !== exp_r) begin n_fail++; $display("FAIL stall_result: got %h want %h", bus.rsp_result, exp_r); end
            n_checks++; if (bus.rsp_id !== IDW'(g)) begin n_fail++; $display("FAIL stall_id: got %0d want %0d", bus.rsp_id, g); end
            n_checks++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL stall_req_ready: got %b want 0", bus.req_ready); end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL idle_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_checks++; if (bus.req_ready !== onehot(pick(v))) begin n_fail++; $display("FAIL regrant: got %b want %b", bus.req_ready, onehot(pick(v))); end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin op_a[i] = 16'h0001; op_b[i] = 16'h0001; end
        drive_ops('1);
        @(negedge clk);
        n_checks++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_result !== 16'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.rsp_result); end
        n_checks++; if (bus.rsp_id !== '0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", bus.rsp_id); end
        n_checks++; if (bus.grant_cnt !== '0) begin n_fail++; $display("FAIL reset_grant_cnt: got %h want 0", bus.grant_cnt); end
        bus.req_valid = '0;
        rst_n = 1'b1;
        mdl_ptr = 0;
        for (int i = 0; i < NREQ; i++) mdl_cnt[i] = 0;
    endtask

    task automatic test_single_op();
        op_a[0] = -16'sd300; op_b[0] = 16'sd7;
        run_op(2'b01, 0);
    endtask

    task automatic test_edges();
        op_a[0] = 16'sd300;  op_b[0] = 16'sd300;  run_op(2'b01, 0);
        op_a[0] = 16'h8000;  op_b[0] = 16'hFFFF;  run_op(2'b01, 0);
        op_a[0] = 16'h0000;  op_b[0] = -16'sd5;   run_op(2'b01, 0);
        op_a[1] = 16'h7FFF;  op_b[1] = 16'h7FFF;  run_op(2'b10, 0);
    endtask

    task automatic test_round_robin();
        apply_reset();
        op_a[0] = 16'd3; op_b[0] = 16'd4;
        op_a[1] = 16'd5; op_b[1] = 16'd6;
        repeat (4) run_op(2'b11, 0);
    endtask

    task automatic test_backpressure();
        op_a[0] = 16'sd1234; op_b[0] = -16'sd9;
        run_op(2'b01, 5);
    endtask

    task automatic test_reset_mid_op();
        op_a[0] = 16'd7; op_b[0] = 16'd9;
        drive_ops(2'b01);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_result !== 16'h0) begin n_fail++; $display("FAIL midrst_result: got %h want 0", bus.rsp_result); end
        n_checks++; if (bus.rsp_id !== '0) begin n_fail++; $display("FAIL midrst_id: got %0d want 0", bus.rsp_id); end
        n_checks++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL midrst_req_ready: got %b want 0", bus.req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = '0;
        mdl_ptr = 0;
        for (int i = 0; i < NREQ; i++) mdl_cnt[i] = 0;
        repeat (3) begin
            @(negedge clk);
            n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_rsp: got %b want 0", bus.rsp_valid); end
        end
        op_a[1] = 16'd11; op_b[1] = 16'd13;
        run_op(2'b11, 0);
    endtask

    task automatic test_random();
        logic [NREQ-1:0] v;
        for (int n = 0; n < 24; n++) begin
            v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                op_a[i] = 16'($urandom);
                op_b[i] = 16'($urandom);
            end
            run_op(v, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_stats();
        apply_reset();
        op_a[1] = 16'd2; op_b[1] = -16'sd3;
        repeat (4) run_op(2'b10, 0);
        n_checks++; if (bus.grant_cnt[31:16] !== exp_cnt(1)) begin n_fail++; $display("FAIL stats_cnt1: got %0d want %0d", bus.grant_cnt[31:16], exp_cnt(1)); end
        n_checks++; if (bus.grant_cnt[15:0] !== exp_cnt(0)) begin n_fail++; $display("FAIL stats_cnt0: got %0d want %0d", bus.grant_cnt[15:0], exp_cnt(0)); end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) mdl_cnt[i] = 0;
        @(negedge clk);
        test_reset();
        test_single_op();
        test_edges();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
